// File: rtl/time_set_controller_if.sv
// Signal bundle between the clock/mode logic (master) and time_set_controller (slave).
interface time_set_controller_if;
  logic tick_1k;
  logic tick_1hz;
  logic normal;
  logic second_setup;
  logic minute_setup;
  logic hour_setup;
  logic inc_n;
  logic sec_inc;
  logic min_inc;
  logic hour_inc;
  logic time_tick;
  logic sec_blank;
  logic min_blank;
  logic hour_blank;

  modport master (
    output tick_1k, tick_1hz, normal, second_setup, minute_setup, hour_setup, inc_n,
    input  sec_inc, min_inc, hour_inc, time_tick, sec_blank, min_blank, hour_blank
  );

  modport slave (
    input  tick_1k, tick_1hz, normal, second_setup, minute_setup, hour_setup, inc_n,
    output sec_inc, min_inc, hour_inc, time_tick, sec_blank, min_blank, hour_blank
  );
endinterface

// File: rtl/time_set_controller.sv
// Increment-button handling, run-time tick gating and field blinking for clock setting.
// Define AUTO_REPEAT_EN to enable hold-to-repeat; otherwise one pulse per press.
module time_set_controller #(
  parameter int DEBOUNCE_MS     = 20,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100,
  parameter int BLINK_HALF_MS   = 250
) (
  input logic                  CLK,
  input logic                  reset,
  time_set_controller_if.slave bus
);
  localparam int DBW = $clog2(DEBOUNCE_MS + 1);
  localparam int BKW = $clog2(BLINK_HALF_MS + 1);

`ifdef AUTO_REPEAT_EN
  localparam int HOLD_MAX = (REPEAT_DELAY_MS > REPEAT_RATE_MS) ? REPEAT_DELAY_MS : REPEAT_RATE_MS;
  localparam int HCW      = $clog2(HOLD_MAX + 1);
  typedef enum logic [1:0] {IDLE = 2'd0, PRESSED = 2'd1, REPEAT = 2'd2} state_t;
  logic [HCW-1:0] hold_cnt_q;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, PRESSED = 2'd1} state_t;
`endif

  state_t         state_q;
  logic           sync1_q;
  logic           sync2_q;
  logic           db_level_q;
  logic [DBW-1:0] db_cnt_q;
  logic [3:0]     mode_q;
  logic [2:0]     sel_q;
  logic [2:0]     inc_q;
  logic           time_tick_q;
  logic           phase_q;
  logic [BKW-1:0] blink_cnt_q;

  logic       db_accept;
  logic       press;
  logic       release_ev;
  logic [3:0] mode;
  logic [2:0] sel;
  logic       mode_change;
  logic       setup_entry;

  // A new level is accepted on the tick that completes the run of differing samples.
  assign db_accept  = bus.tick_1k && (sync2_q != db_level_q) &&
                      (db_cnt_q == DBW'(DEBOUNCE_MS - 1));
  assign press      = db_accept && db_level_q;
  assign release_ev = db_accept && !db_level_q;

  assign mode = {bus.normal, bus.second_setup, bus.minute_setup, bus.hour_setup};
  assign sel  = (mode == 4'b0100) ? 3'b100 :
                (mode == 4'b0010) ? 3'b010 :
                (mode == 4'b0001) ? 3'b001 : 3'b000;
  assign mode_change = (mode != mode_q);
  assign setup_entry = mode_change && (sel != 3'b000);

  always_ff @(posedge CLK) begin
    if (!reset) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      db_level_q <= 1'b1;
      db_cnt_q   <= '0;
    end else begin
      sync1_q <= bus.inc_n;
      sync2_q <= sync1_q;
      if (bus.tick_1k) begin
        if (sync2_q == db_level_q) begin
          db_cnt_q <= '0;
        end else if (db_accept) begin
          db_level_q <= sync2_q;
          db_cnt_q   <= '0;
        end else begin
          db_cnt_q <= db_cnt_q + DBW'(1);
        end
      end
    end
  end

  // Press FSM; any mode change or non-setup mode parks it in IDLE without a pulse.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q     <= IDLE;
      inc_q       <= '0;
      time_tick_q <= 1'b0;
`ifdef AUTO_REPEAT_EN
      hold_cnt_q  <= '0;
`endif
    end else begin
      inc_q       <= '0;
      time_tick_q <= bus.tick_1hz & bus.normal;
      if ((sel == 3'b000) || mode_change) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (press) begin
              inc_q   <= sel;
              state_q <= PRESSED;
`ifdef AUTO_REPEAT_EN
              hold_cnt_q <= '0;
`endif
            end
          end
          PRESSED: begin
            if (release_ev) begin
              state_q <= IDLE;
`ifdef AUTO_REPEAT_EN
            end else if (bus.tick_1k) begin
              if (hold_cnt_q == HCW'(REPEAT_DELAY_MS - 1)) begin
                inc_q      <= sel;
                hold_cnt_q <= '0;
                state_q    <= REPEAT;
              end else begin
                hold_cnt_q <= hold_cnt_q + HCW'(1);
              end
`endif
            end
          end
`ifdef AUTO_REPEAT_EN
          REPEAT: begin
            // Release wins over a coincident repeat tick.
            if (release_ev) begin
              state_q <= IDLE;
            end else if (bus.tick_1k) begin
              if (hold_cnt_q == HCW'(REPEAT_RATE_MS - 1)) begin
                inc_q      <= sel;
                hold_cnt_q <= '0;
              end else begin
                hold_cnt_q <= hold_cnt_q + HCW'(1);
              end
            end
          end
`endif
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      mode_q      <= '0;
      sel_q       <= '0;
      phase_q     <= 1'b0;
      blink_cnt_q <= '0;
    end else begin
      mode_q <= mode;
      sel_q  <= sel;
      if (setup_entry) begin
        phase_q     <= 1'b0;
        blink_cnt_q <= '0;
      end else if (bus.tick_1k) begin
        if (blink_cnt_q == BKW'(BLINK_HALF_MS - 1)) begin
          phase_q     <= ~phase_q;
          blink_cnt_q <= '0;
        end else begin
          blink_cnt_q <= blink_cnt_q + BKW'(1);
        end
      end
    end
  end

  assign bus.sec_inc    = inc_q[2];
  assign bus.min_inc    = inc_q[1];
  assign bus.hour_inc   = inc_q[0];
  assign bus.time_tick  = time_tick_q;
  assign bus.sec_blank  = sel_q[2] & phase_q & (state_q == IDLE);
  assign bus.min_blank  = sel_q[1] & phase_q & (state_q == IDLE);
  assign bus.hour_blank = sel_q[0] & phase_q & (state_q == IDLE);

endmodule
